instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 123 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a synchronous ROM,
// buffers the returned words with their addresses, and hands them to decode
// through a valid/ready head. A redirect flushes everything and restarts
// the fetch stream at the new target.
module instr_fetch_queue #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 24,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_rden,
    input  logic [INSTR_W-1:0]         imem_q,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]     rd_ptr_q,      rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q,      wr_ptr_d;
    logic [CW-1:0]     count_q,       count_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] issue_addr;
    logic [CW:0]       occupancy;

    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue_addr = redirect_valid ? redirect_pc : fetch_pc_q;

    // Issue, handshake and output gating; reset and redirect override everything.
    always_comb begin
        issue = 1'b0;
        if (!rst) begin
            issue = redirect_valid || (occupancy < DEPTH_L);
        end
        // A response landing in a redirect cycle belongs to the old stream.
        push      = !rst && !redirect_valid && inflight_q;
        out_valid = !rst && !redirect_valid && (count_q != '0);
        pop       = out_valid && out_ready;
        imem_rden = issue;
        imem_addr = rst ? '0 : issue_addr;
        out_instr = rst ? '0 : instr_mem_q[rd_ptr_q];
        out_pc    = rst ? '0 : pc_mem_q[rd_ptr_q];
        count     = rst ? '0 : count_q;
    end

    // Next-state for fetch PC, in-flight tracking, pointers and occupancy.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (issue) begin
            fetch_pc_d    = issue_addr + ADDR_W'(1);
            inflight_pc_d = issue_addr;
        end
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Entry storage: write the returning ROM word and its address at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_q;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized self-checking bench for instr_fetch_queue with a queue-based
// reference model of the fetch stream; a second instance checks PC wrap.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    logic [15:0] imem_addr;
    logic        imem_rden;
    logic [23:0] imem_q;
    logic        out_valid;
    logic [23:0] out_instr;
    logic [15:0] out_pc;
    logic [2:0]  count;

    logic [15:0] imem_addr_w;
    logic        imem_rden_w;
    logic [23:0] imem_q_w;
    logic        out_valid_w;
    logic [23:0] out_instr_w;
    logic [15:0] out_pc_w;
    logic [2:0]  count_w;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: delivered-but-not-popped PCs, pending fetch, next PC.
    logic [15:0] mq [$];
    logic        pend_v = 1'b0;
    logic [15:0] pend_pc = '0;
    logic [15:0] mpc = '0;
    int unsigned obs_hs = 0;

    logic [15:0] wexp [4];
    int unsigned w_idx = 0;
    logic        w_collect = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .ADDR_W(16), .INSTR_W(24), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_q(imem_q),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .count(count)
    );

    instr_fetch_queue #(
        .ADDR_W(16), .INSTR_W(24), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)
    ) dut_w (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr_w), .imem_rden(imem_rden_w), .imem_q(imem_q_w),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .out_valid(out_valid_w), .out_ready(1'b1),
        .out_instr(out_instr_w), .out_pc(out_pc_w), .count(count_w)
    );

    // Synchronous ROMs returning addr + 0x100000.
    always_ff @(posedge clk) begin
        if (imem_rden) imem_q <= 24'h100000 + {8'h00, imem_addr};
    end
    always_ff @(posedge clk) begin
        if (imem_rden_w) imem_q_w <= 24'h100000 + {8'h00, imem_addr_w};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against model, advance model.
    task automatic cycle(input logic r, input logic rv, input logic [15:0] rpc, input logic rdy);
        logic        e_valid;
        logic        e_rden;
        int unsigned occ;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        #1;
        occ     = mq.size() + (pend_v ? 1 : 0);
        e_valid = !r && !rv && (mq.size() != 0);
        e_rden  = !r && (rv || occ < DEPTH);
        check_eq("count", {29'b0, count}, r ? 0 : mq.size());
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        check_eq("imem_rden", {31'b0, imem_rden}, {31'b0, e_rden});
        if (r) begin
            check_eq("rst_addr", {16'b0, imem_addr}, 0);
            check_eq("rst_pc", {16'b0, out_pc}, 0);
            check_eq("rst_instr", {8'b0, out_instr}, 0);
            check_eq("rst_count_w", {29'b0, count_w}, 0);
            check_eq("rst_valid_w", {31'b0, out_valid_w}, 0);
        end else if (e_rden) begin
            check_eq("imem_addr", {16'b0, imem_addr}, {16'b0, rv ? rpc : mpc});
        end
        if (e_valid) begin
            check_eq("out_pc", {16'b0, out_pc}, {16'b0, mq[0]});
            check_eq("out_instr", {8'b0, out_instr}, 32'h100000 + {16'b0, mq[0]});
        end
        if (out_valid && out_ready) obs_hs++;
        if (w_collect && out_valid_w && w_idx < 4) begin
            check_eq("wrap_pc", {16'b0, out_pc_w}, {16'b0, wexp[w_idx]});
            check_eq("wrap_instr", {8'b0, out_instr_w}, 32'h100000 + {16'b0, wexp[w_idx]});
            w_idx++;
        end
        if (r) begin
            mq.delete(); pend_v = 1'b0; mpc = 16'h0000;
        end else if (rv) begin
            mq.delete(); pend_v = 1'b1; pend_pc = rpc; mpc = rpc + 16'd1;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (pend_v) mq.push_back(pend_pc);
            pend_v = e_rden;
            if (e_rden) begin
                pend_pc = mpc;
                mpc = mpc + 16'd1;
            end
        end
    endtask

    initial begin
        int first_valid;
        int unsigned fetches;
        int unsigned hs_before;
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;

        // Reset, then free-running delivery with out_ready high.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        w_collect = 1'b1;
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
            if (out_valid && first_valid < 0) first_valid = i;
        end
        check_eq("first_valid_latency", first_valid, 2);
        check_eq("wrap_delivered", w_idx, 4);
        w_collect = 1'b0;

        // Stall from release: exactly DEPTH fetches, then drain and resume.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        fetches = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0);
            if (imem_rden) fetches++;
        end
        check_eq("stall_fetches", fetches, 4);
        check_eq("stall_count", {29'b0, count}, 4);
        check_eq("stall_head_pc", {16'b0, out_pc}, 0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect with ready high and count=3: no pop in the redirect cycle.
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        hs_before = obs_hs;
        cycle(1'b0, 1'b1, 16'h0040, 1'b1);
        check_eq("redir_no_pop", obs_hs, hs_before);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Back-to-back redirects, last one wrapping the fetch PC.
        cycle(1'b0, 1'b1, 16'h1234, 1'b1);
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Mid-operation single-cycle reset with data queued and a fetch in flight.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0077, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        rv;
            logic [15:0] rpc;
            logic        rdy;
            r   = ($urandom_range(0, 79) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                              : 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(r, rv, rpc, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
